// File: rtl/ervp_mmio_wide_reg_arbiter.sv
// ervp_mmio_wide_reg_arbiter: round-robin arbiter that hands one MMIO requester
// a complete NUM_WORDS-access burst on a multi-word wide register port.
`default_nettype none

module ervp_mmio_wide_reg_arbiter #(
  parameter int BW_MMIO      = 32,
  parameter int BW_WIDE_DATA = 32,
  parameter int NUM_REQ      = 2,
  localparam int NUM_WORDS_RAW = (BW_WIDE_DATA + BW_MMIO - 1) / BW_MMIO,
  localparam int NUM_WORDS     = (NUM_WORDS_RAW < 1) ? 1 : NUM_WORDS_RAW,
  localparam int BW_INDEX      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                       clk,
  input  logic                       rstnn,
  input  logic                       clear,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_access,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*BW_MMIO-1:0] req_wdata,
  output logic [NUM_REQ-1:0]         req_grant,
  output logic [BW_MMIO-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]         req_owner,
  output logic                       busy,
  output logic [BW_INDEX-1:0]        word_index,
  output logic                       wreg_enable,
  output logic                       wreg_clear,
  output logic                       wreg_re,
  output logic                       wreg_we,
  output logic [BW_MMIO-1:0]         wreg_wdata,
  input  logic [BW_MMIO-1:0]         wreg_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [BW_INDEX-1:0] LAST_WORD = BW_INDEX'(NUM_WORDS - 1);
  localparam logic [NUM_REQ-1:0]  LS_RESET  = {1'b1, {(NUM_REQ-1){1'b0}}};

  state_t                r_state;
  logic [NUM_REQ-1:0]    r_owner;
  logic [NUM_REQ-1:0]    r_last_served;
  logic [BW_INDEX-1:0]   r_word_cnt;

  int                    w_ls_idx;
  logic [2*NUM_REQ-1:0]  w_req_dbl;
  logic [NUM_REQ-1:0]    w_rot;
  logic [NUM_REQ-1:0]    w_first;
  logic [2*NUM_REQ-1:0]  w_gnt_dbl;
  logic [NUM_REQ-1:0]    w_rr_pick;
  logic [NUM_REQ-1:0]    w_grant;
  logic [BW_MMIO-1:0]    w_wdata;
  logic                  w_go;
  logic                  w_any;
  logic                  w_gnt_we;

  // Rotate requests so the slot after last_served sits at bit 0, take the
  // lowest set bit, then rotate the pick back into requester numbering.
  always_comb begin
    w_ls_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_last_served[i]) w_ls_idx = i;
    end
    w_req_dbl = {req_access, req_access};
    w_rot     = NUM_REQ'(w_req_dbl >> (w_ls_idx + 1));
    w_first   = w_rot & (-w_rot);
    w_gnt_dbl = {{NUM_REQ{1'b0}}, w_first} << (w_ls_idx + 1);
    w_rr_pick = w_gnt_dbl[NUM_REQ-1:0] | w_gnt_dbl[2*NUM_REQ-1:NUM_REQ];
  end

  assign w_go = enable & ~clear;

  always_comb begin
    w_grant = '0;
    if (w_go) begin
      if (r_state == ST_LOCKED) w_grant = r_owner & req_access;
      else                      w_grant = w_rr_pick;
    end
  end

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_wdata = w_wdata | req_wdata[BW_MMIO*(i+1)-1 -: BW_MMIO];
    end
  end

  assign w_any    = |w_grant;
  assign w_gnt_we = |(w_grant & req_we);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state       <= ST_IDLE;
      r_owner       <= '0;
      r_word_cnt    <= '0;
      r_last_served <= LS_RESET;
    end else if (clear) begin
      r_state       <= ST_IDLE;
      r_owner       <= '0;
      r_word_cnt    <= '0;
      r_last_served <= LS_RESET;
    end else if (w_any) begin
      if (r_word_cnt == LAST_WORD) begin
        // Single-word registers land here on every grant, so they never lock.
        r_state       <= ST_IDLE;
        r_owner       <= '0;
        r_word_cnt    <= '0;
        r_last_served <= w_grant;
      end else begin
        r_state    <= ST_LOCKED;
        r_owner    <= w_grant;
        r_word_cnt <= r_word_cnt + BW_INDEX'(1);
      end
    end
  end

  assign req_grant   = w_grant;
  assign req_rdata   = wreg_rdata;
  assign req_owner   = r_owner;
  assign busy        = (r_state == ST_LOCKED);
  assign word_index  = r_word_cnt;
  assign wreg_enable = enable;
  assign wreg_clear  = clear;
  assign wreg_re     = w_any & ~w_gnt_we;
  assign wreg_we     = w_gnt_we;
  assign wreg_wdata  = w_wdata;

endmodule

`default_nettype wire

// File: doc/ervp_mmio_wide_reg_arbiter.md
# ervp_mmio_wide_reg_arbiter

Arbitrates one multi-word MMIO wide register port among NUM_REQ software-visible requesters. A wide register is accessed as NUM_WORDS consecutive word accesses, with its internal word pointer advancing on every read or write. Interleaved accesses from different requesters would therefore corrupt it. This block grants the port to one requester for a complete NUM_WORDS-access burst, round-robin, and sits directly between the MMIO decode fabric and the wide register.

## Interface
Parameters:
- BW_MMIO, 32, MMIO word width.
- BW_WIDE_DATA, 32, wide register width; NUM_WORDS = ceil(BW_WIDE_DATA/BW_MMIO), minimum 1.
- NUM_REQ, 2, number of requesters, ≥2.

Ports:
- clk  in  1  clock.
- rstnn  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort/reinit.
- enable  in  1  global enable; no grants while low.
- req_access  in  NUM_REQ  per-requester access request (read or write).
- req_we  in  NUM_REQ  per-requester write flag (1=write, 0=read).
- req_wdata  in  NUM_REQ*BW_MMIO  per-requester write word; requester i uses bits [BW_MMIO*(i+1)-1 -: BW_MMIO].
- req_grant  out  NUM_REQ  one-hot; access accepted this cycle.
- req_rdata  out  BW_MMIO  read data, valid in the grant cycle.
- req_owner  out  NUM_REQ  one-hot current burst owner, 0 when idle.
- busy  out  1  burst in progress.
- word_index  out  clog2(NUM_WORDS) (min 1)  index of the next word to be accessed.
- wreg_enable  out  1  = enable.
- wreg_clear  out  1  = clear.
- wreg_re / wreg_we  out  1  access strobes to the wide register.
- wreg_wdata  out  BW_MMIO  granted requester's write word.
- wreg_rdata  in  BW_MMIO  wide register read mux output.

## Operation
- States:
  - IDLE: no owner.
  - LOCKED: owner register holds a one-hot requester.
- State registers:
  - word_cnt: 0..NUM_WORDS-1.
  - last_served: one-hot; reset value is requester NUM_REQ-1, so requester 0 wins first.
- IDLE, enable=1, clear=0, any req_access:
  - The winner is the first requesting index after last_served, circular.
  - The winner is granted in the same cycle.
- LOCKED:
  - Only the owner can be granted, when its req_access=1.
  - Other requesters see req_grant=0 and must hold their request.
  - An idle owner keeps the lock indefinitely.
- Granted access:
  - wreg_re = ~req_we[g], wreg_we = req_we[g], wreg_wdata = winner's word.
  - req_rdata = wreg_rdata.
  - word_cnt increments.
- Burst completion: when word_cnt reaches NUM_WORDS-1 and is granted, word_cnt returns to 0, state returns to IDLE, last_served becomes the owner, and req_owner returns to 0.
- Burst start:
  - NUM_WORDS>1: IDLE→LOCKED at the first grant, owner latched.
  - NUM_WORDS=1: state stays IDLE and last_served updates on every grant.
- Reads and writes may be mixed within a burst; each counts as one word.
- clear=1:
  - No grants; wreg_re and wreg_we are 0.
  - State→IDLE, word_cnt=0, last_served reset value.
  - clear overrides a simultaneous access or burst completion.
- enable=0: no grants, all state frozen.
- Reset values (async on rstnn low): IDLE, word_cnt 0, last_served=requester NUM_REQ-1. Resulting outputs: req_grant 0, req_owner 0, busy 0, word_index 0, wreg_re 0, wreg_we 0, wreg_wdata 0.
- Invariant: word_cnt equals the wide register's one-hot pointer position, because both advance on the same gated accesses and clear together.

## Timing
- The grant path is combinational from req_access, enable, clear and state to req_grant, wreg_re and wreg_we. Latency is 0 cycles.
- req_rdata is combinational from wreg_rdata in the grant cycle.
- State, word_cnt and last_served update on posedge clk after a grant.
- busy=1 from the cycle after the first grant through the last-word grant cycle. It drops the cycle after completion.
- Back-to-back bursts are allowed: IDLE arbitration happens in the cycle immediately after the completing grant.
- Maximum throughput is one word per cycle.

## Test plan
Default configuration unless stated: NUM_REQ=2, BW_MMIO=32, BW_WIDE_DATA=96 (3 words).
- Requester 0 writes 0xA, 0xB, 0xC on 3 consecutive cycles while requester 1 holds req_access=1 -> requester 1 gets 0 grants for 3 cycles, the wide register reads 0x0000000C_0000000B_0000000A, and requester 1 is granted in cycle 4.
- Both requesters request continuously after reset -> requester 0 bursts first, then requester 1, then requester 0 (round-robin). Each burst is exactly 3 grants.
- Owner requester 1 drops req_access for 2 cycles after word 1 -> busy stays 1, requester 0 stays blocked, word_index stays 1, and the burst resumes and completes.
- clear is pulsed after 1 written word of a burst -> req_grant 0 in that cycle, wreg_clear 1, busy 0 next cycle, and the next burst starts at word_index 0.
- BW_WIDE_DATA=32 (NUM_WORDS=1), both requesting -> grants alternate 0, 1, 0, 1 every cycle and busy stays 0.
- enable=0 for 3 cycles mid-burst, then rstnn asserted mid-burst -> no grants and state frozen while enable is low; after reset all outputs are 0 and requester 0 wins first.
